// File: rtl/perf_monitor.sv
// On-chip performance monitor: counts cycles, retired instructions, bus reads/writes
// and generic events while the CPU runs, with a coherent multi-word snapshot readout.
module perf_monitor #(
   parameter int PC_WIDTH   = 10,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 32,
   parameter int NUM_EVENTS = 2,
   parameter int SATURATE   = 1,
   localparam int NCNT      = 4 + NUM_EVENTS,
   localparam int SEL_W     = $clog2(NCNT),
   localparam int EV_W      = (NUM_EVENTS > 0) ? NUM_EVENTS : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  halted,
   input  logic [EV_W-1:0]       event_in,
   input  logic                  rd_en,
   input  logic [SEL_W-1:0]      rd_sel,
   input  logic [1:0]            rd_word,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  running,
   output logic                  done,
   output logic [NCNT-1:0]       overflow
);

   localparam int NWORDS = CNT_WIDTH / DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   running_q, done_q;
   logic                   countEn;

   logic [CNT_WIDTH-1:0]   cnt_q [NCNT];
   logic [CNT_WIDTH-1:0]   cnt_d [NCNT];
   logic [NCNT-1:0]        ovf_q, ovf_d;
   logic [NCNT-1:0]        incr;
   logic [PC_WIDTH-1:0]    lastPc_q, lastPc_d;

   logic [CNT_WIDTH-1:0]   shadow_q, shadow_d;
   logic [CNT_WIDTH-1:0]   selCnt;
   logic                   selInRange;
   logic [DATA_WIDTH-1:0]  wordSlice;
   logic                   wordInRange;
   logic [DATA_WIDTH-1:0]  rdData_q, rdData_d;
   logic                   rdValid_q;

   // start overrides everything; halted or stop freezes a run without counting that edge
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = RUN;
      end else if ((state_q == RUN) && (halted || stop)) begin
         state_d = FROZEN;
      end
   end

   assign countEn = (state_q == RUN) && !start && !halted && !stop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == FROZEN);
      end
   end

   always_comb begin
      incr    = '0;
      incr[0] = 1'b1;
      incr[1] = (pc != lastPc_q);
      incr[2] = mem_read;
      incr[3] = mem_write;
      for (int k = 0; k < NUM_EVENTS; k++) begin
         incr[4+k] = event_in[k];
      end
   end

   // last_pc restarts at all ones so the first counted PC always retires an instruction
   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      lastPc_d = lastPc_q;
      if (start) begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = '0;
         end
         ovf_d    = '0;
         lastPc_d = '1;
      end else if (countEn) begin
         lastPc_d = pc;
         for (int i = 0; i < NCNT; i++) begin
            if (incr[i]) begin
               if (&cnt_q[i]) begin
                  ovf_d[i] = 1'b1;
                  cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_q    <= '0;
         lastPc_q <= '1;
      end else begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q    <= ovf_d;
         lastPc_q <= lastPc_d;
      end
   end

   always_comb begin
      selCnt     = '0;
      selInRange = 1'b0;
      for (int i = 0; i < NCNT; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            selCnt     = cnt_q[i];
            selInRange = 1'b1;
         end
      end
   end

   always_comb begin
      wordSlice   = '0;
      wordInRange = 1'b0;
      for (int w = 0; w < NWORDS; w++) begin
         if (rd_word == 2'(w)) begin
            wordSlice   = shadow_q[w*DATA_WIDTH +: DATA_WIDTH];
            wordInRange = 1'b1;
         end
      end
   end

   // Word 0 relatches the whole counter so later words come from the same instant
   always_comb begin
      shadow_d = shadow_q;
      rdData_d = rdData_q;
      if (rd_en) begin
         if (!selInRange || !wordInRange) begin
            rdData_d = '0;
         end else if (rd_word == 2'd0) begin
            shadow_d = selCnt;
            rdData_d = selCnt[DATA_WIDTH-1:0];
         end else begin
            rdData_d = wordSlice;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q  <= '0;
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         rdData_q  <= rdData_d;
         rdValid_q <= rd_en;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
   assign running  = running_q;
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed self-checking bench for perf_monitor: a default instance plus two
// narrow 16-bit instances (saturating and wrapping) that exercise overflow.
module tb_perf_monitor;

   logic        clk;
   logic        reset;

   logic        start, stop, memRead, memWrite, halted, rdEn;
   logic [9:0]  pc;
   logic [1:0]  eventIn;
   logic [2:0]  rdSel;
   logic [1:0]  rdWord;
   logic [15:0] rdData;
   logic        rdValid, running, done;
   logic [5:0]  overflow;

   logic        ovStart, ovStop, ovHalted, ovRdEn, ovZero;
   logic [9:0]  ovPc;
   logic [1:0]  ovEvent;
   logic [2:0]  ovRdSel;
   logic [1:0]  ovRdWord;
   logic [7:0]  satRdData, wrapRdData;
   logic        satRdValid, wrapRdValid, satRunning, wrapRunning, satDone, wrapDone;
   logic [5:0]  satOverflow, wrapOverflow;

   int checks;
   int errors;

   logic [9:0] pcSeq  [6] = '{10'd0, 10'd0, 10'd1, 10'd2, 10'd2, 10'd3};
   // each entry is {mem_read, mem_write, event0, event1}
   logic [3:0] memSeq [6] = '{4'b1110, 4'b1010, 4'b0010, 4'b1000, 4'b0100, 4'b0001};

   perf_monitor dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pc(pc),
      .mem_read(memRead), .mem_write(memWrite), .halted(halted), .event_in(eventIn),
      .rd_en(rdEn), .rd_sel(rdSel), .rd_word(rdWord), .rd_data(rdData),
      .rd_valid(rdValid), .running(running), .done(done), .overflow(overflow)
   );

   perf_monitor #(.CNT_WIDTH(16), .DATA_WIDTH(8), .SATURATE(1)) dutSat (
      .clk(clk), .reset(reset), .start(ovStart), .stop(ovStop), .pc(ovPc),
      .mem_read(ovZero), .mem_write(ovZero), .halted(ovHalted), .event_in(ovEvent),
      .rd_en(ovRdEn), .rd_sel(ovRdSel), .rd_word(ovRdWord), .rd_data(satRdData),
      .rd_valid(satRdValid), .running(satRunning), .done(satDone), .overflow(satOverflow)
   );

   perf_monitor #(.CNT_WIDTH(16), .DATA_WIDTH(8), .SATURATE(0)) dutWrap (
      .clk(clk), .reset(reset), .start(ovStart), .stop(ovStop), .pc(ovPc),
      .mem_read(ovZero), .mem_write(ovZero), .halted(ovHalted), .event_in(ovEvent),
      .rd_en(ovRdEn), .rd_sel(ovRdSel), .rd_word(ovRdWord), .rd_data(wrapRdData),
      .rd_valid(wrapRdValid), .running(wrapRunning), .done(wrapDone), .overflow(wrapOverflow)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic readMain(input logic [2:0] sel, input logic [1:0] word,
                           output logic [15:0] data, output logic valid);
      rdEn   = 1'b1;
      rdSel  = sel;
      rdWord = word;
      tick();
      data   = rdData;
      valid  = rdValid;
      rdEn   = 1'b0;
   endtask

   task automatic readOv(input logic [2:0] sel, input logic [1:0] word,
                         output logic [7:0] satD, output logic [7:0] wrapD);
      ovRdEn   = 1'b1;
      ovRdSel  = sel;
      ovRdWord = word;
      tick();
      satD     = satRdData;
      wrapD    = wrapRdData;
      ovRdEn   = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      logic        v;
      reset = 1'b1;
      #1;
      checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %0b expected 0", running); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", done); end
      checks++; if (overflow !== 6'd0) begin errors++; $display("[TB] FAIL reset_overflow got %0h expected 0", overflow); end
      checks++; if (rdValid !== 1'b0 || rdData !== 16'd0) begin errors++; $display("[TB] FAIL reset_rd got data %0h valid %0b expected 0/0", rdData, rdValid); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) tick();
      readMain(3'd0, 2'd0, d, v);
      checks++; if (v !== 1'b1 || d !== 16'd0) begin errors++; $display("[TB] FAIL idle_cycles got %0h valid %0b expected 0 valid 1", d, v); end
   endtask

   task automatic test_instr_count();
      logic [15:0] d;
      logic        v;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (running !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL start_run got running %0b done %0b expected 1/0", running, done); end
      for (int i = 0; i < 6; i++) begin
         pc = pcSeq[i];
         tick();
      end
      halted = 1'b1;
      tick();
      checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("[TB] FAIL halt_freeze got running %0b done %0b expected 0/1", running, done); end
      halted = 1'b0;
      pc = 10'd5;
      tick();
      pc = 10'd7;
      tick();
      readMain(3'd0, 2'd0, d, v);
      checks++; if (d !== 16'd6) begin errors++; $display("[TB] FAIL instr_cycles got %0d expected 6", d); end
      readMain(3'd1, 2'd0, d, v);
      checks++; if (d !== 16'd4) begin errors++; $display("[TB] FAIL instr_count got %0d expected 4", d); end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL frozen_stays got done %0b expected 1", done); end
   endtask

   task automatic test_mem_events();
      logic [15:0] d;
      logic        v;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         memRead  = memSeq[i][3];
         memWrite = memSeq[i][2];
         eventIn  = {memSeq[i][0], memSeq[i][1]};
         tick();
      end
      memRead  = 1'b0;
      memWrite = 1'b0;
      eventIn  = 2'b00;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL stop_freeze got done %0b expected 1", done); end
      readMain(3'd2, 2'd0, d, v);
      checks++; if (d !== 16'd3) begin errors++; $display("[TB] FAIL mem_reads got %0d expected 3", d); end
      readMain(3'd3, 2'd0, d, v);
      checks++; if (d !== 16'd2) begin errors++; $display("[TB] FAIL mem_writes got %0d expected 2", d); end
      readMain(3'd0, 2'd0, d, v);
      checks++; if (d !== 16'd6) begin errors++; $display("[TB] FAIL mem_cycles got %0d expected 6", d); end
      readMain(3'd1, 2'd0, d, v);
      checks++; if (d !== 16'd1) begin errors++; $display("[TB] FAIL const_pc_instr got %0d expected 1", d); end
      checks++; if (overflow !== 6'd0) begin errors++; $display("[TB] FAIL mem_overflow got %0h expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      rdEn = 1'b1;
      rdSel = 3'd2; rdWord = 2'd0;
      tick();
      checks++; if (rdData !== 16'd3 || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reads got %0h valid %0b expected 3/1", rdData, rdValid); end
      rdSel = 3'd2; rdWord = 2'd1;
      tick();
      checks++; if (rdData !== 16'd0 || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word1 got %0h valid %0b expected 0/1", rdData, rdValid); end
      rdSel = 3'd4; rdWord = 2'd0;
      tick();
      checks++; if (rdData !== 16'd3) begin errors++; $display("[TB] FAIL b2b_event0 got %0h expected 3", rdData); end
      rdSel = 3'd3; rdWord = 2'd2;
      tick();
      checks++; if (rdData !== 16'd0 || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_word_range got %0h valid %0b expected 0/1", rdData, rdValid); end
      rdSel = 3'd5; rdWord = 2'd0;
      tick();
      checks++; if (rdData !== 16'd1) begin errors++; $display("[TB] FAIL b2b_event1 got %0h expected 1", rdData); end
      rdEn = 1'b0;
      tick();
      checks++; if (rdValid !== 1'b0 || rdData !== 16'd1) begin errors++; $display("[TB] FAIL rd_idle got %0h valid %0b expected 1/0", rdData, rdValid); end
   endtask

   task automatic test_snapshot_overflow();
      logic [15:0] d;
      logic        v;
      logic [7:0]  sd, wd;
      start   = 1'b1;
      ovStart = 1'b1;
      tick();
      start   = 1'b0;
      ovStart = 1'b0;
      for (int k = 1; k <= 65543; k++) begin
         rdEn   = (k == 65536) || (k == 65540) || (k == 65541) || (k == 65542);
         rdSel  = (k == 65542) ? 3'd7 : 3'd0;
         rdWord = (k == 65540) ? 2'd1 : 2'd0;
         stop   = (k == 65543);
         ovStop = (k == 65538);
         tick();
         if (k == 65536) begin
            checks++; if (rdData !== 16'hFFFF || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL snap_word0 got %0h valid %0b expected ffff/1", rdData, rdValid); end
         end
         if (k == 65537) begin
            checks++; if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL snap_no_req got valid %0b expected 0", rdValid); end
         end
         if (k == 65540) begin
            checks++; if (rdData !== 16'h0000 || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL snap_word1 got %0h valid %0b expected 0/1", rdData, rdValid); end
         end
         if (k == 65541) begin
            checks++; if (rdData !== 16'h0004) begin errors++; $display("[TB] FAIL snap_relatch got %0h expected 4", rdData); end
         end
         if (k == 65542) begin
            checks++; if (rdData !== 16'h0000 || rdValid !== 1'b1) begin errors++; $display("[TB] FAIL snap_bad_sel got %0h valid %0b expected 0/1", rdData, rdValid); end
         end
      end
      rdEn   = 1'b0;
      stop   = 1'b0;
      ovStop = 1'b0;
      readMain(3'd0, 2'd0, d, v);
      checks++; if (d !== 16'h0006) begin errors++; $display("[TB] FAIL long_cycles_lo got %0h expected 6", d); end
      readMain(3'd0, 2'd1, d, v);
      checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL long_cycles_hi got %0h expected 1", d); end
      checks++; if (satDone !== 1'b1 || wrapDone !== 1'b1) begin errors++; $display("[TB] FAIL ov_frozen got %0b/%0b expected 1/1", satDone, wrapDone); end
      readOv(3'd0, 2'd0, sd, wd);
      checks++; if (sd !== 8'hFF) begin errors++; $display("[TB] FAIL sat_lo got %0h expected ff", sd); end
      checks++; if (wd !== 8'h01) begin errors++; $display("[TB] FAIL wrap_lo got %0h expected 01", wd); end
      readOv(3'd0, 2'd1, sd, wd);
      checks++; if (sd !== 8'hFF) begin errors++; $display("[TB] FAIL sat_hi got %0h expected ff", sd); end
      checks++; if (wd !== 8'h00) begin errors++; $display("[TB] FAIL wrap_hi got %0h expected 00", wd); end
      checks++; if (satOverflow !== 6'b000001) begin errors++; $display("[TB] FAIL sat_overflow got %0h expected 1", satOverflow); end
      checks++; if (wrapOverflow !== 6'b000001) begin errors++; $display("[TB] FAIL wrap_overflow got %0h expected 1", wrapOverflow); end
      checks++; if (overflow !== 6'd0) begin errors++; $display("[TB] FAIL main_no_overflow got %0h expected 0", overflow); end
   endtask

   task automatic test_start_priority();
      logic [7:0] sd, wd;
      ovStart  = 1'b1;
      ovHalted = 1'b1;
      tick();
      ovStart  = 1'b0;
      checks++; if (satRunning !== 1'b1 || satDone !== 1'b0) begin errors++; $display("[TB] FAIL start_wins got running %0b done %0b expected 1/0", satRunning, satDone); end
      checks++; if (satOverflow !== 6'd0 || wrapOverflow !== 6'd0) begin errors++; $display("[TB] FAIL start_clears_ovf got %0h/%0h expected 0/0", satOverflow, wrapOverflow); end
      readOv(3'd0, 2'd0, sd, wd);
      checks++; if (satDone !== 1'b1 || satRunning !== 1'b0) begin errors++; $display("[TB] FAIL halt_after_start got running %0b done %0b expected 0/1", satRunning, satDone); end
      checks++; if (sd !== 8'h00 || wd !== 8'h00) begin errors++; $display("[TB] FAIL zero_cycles got %0h/%0h expected 0/0", sd, wd); end
      readOv(3'd0, 2'd1, sd, wd);
      checks++; if (sd !== 8'h00 || wd !== 8'h00) begin errors++; $display("[TB] FAIL zero_cycles_hi got %0h/%0h expected 0/0", sd, wd); end
      ovHalted = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [15:0] d;
      logic        v;
      start = 1'b1;
      tick();
      start = 1'b0;
      pc = 10'd1; tick();
      pc = 10'd2; tick();
      pc = 10'd3; tick();
      readMain(3'd0, 2'd0, d, v);
      checks++; if (d !== 16'd3) begin errors++; $display("[TB] FAIL pre_reset_cycles got %0d expected 3", d); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL async_state got running %0b done %0b expected 0/0", running, done); end
      checks++; if (rdData !== 16'd0 || rdValid !== 1'b0) begin errors++; $display("[TB] FAIL async_rd got %0h valid %0b expected 0/0", rdData, rdValid); end
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      readMain(3'd1, 2'd0, d, v);
      checks++; if (d !== 16'd0 || running !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got %0h running %0b expected 0/0", d, running); end
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      readMain(3'd0, 2'd0, d, v);
      checks++; if (d !== 16'd5) begin errors++; $display("[TB] FAIL restart_cycles got %0d expected 5", d); end
   endtask

   // Run every scenario in order, then report
   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      start = 1'b0; stop = 1'b0; halted = 1'b0; pc = 10'd0;
      memRead = 1'b0; memWrite = 1'b0; eventIn = 2'b00;
      rdEn = 1'b0; rdSel = 3'd0; rdWord = 2'd0;
      ovStart = 1'b0; ovStop = 1'b0; ovHalted = 1'b0; ovZero = 1'b0;
      ovPc = 10'd0; ovEvent = 2'b00; ovRdEn = 1'b0; ovRdSel = 3'd0; ovRdWord = 2'd0;
      #1;
      test_reset();
      test_instr_count();
      test_mem_events();
      test_back_to_back();
      test_snapshot_overflow();
      test_start_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
Synthesisable, parametrised performance monitor that attaches to the CPU-side signals `pc`, `mem_read`, `mem_write` and `halted`. It counts cycles, retired instructions (a PC change), memory reads, memory writes and NUM_EVENTS generic events in hardware. Counting freezes automatically on `halted` or `stop`. A snapshot readout port returns each counter DATA_WIDTH bits at a time, with coherent multi-word reads. It is the on-chip successor to bench-side counting, usable on FPGA runs. CPI is derived in software.

Parameters:
PC_WIDTH, 10, width of the `pc` input
DATA_WIDTH, 16, readout word width
CNT_WIDTH, 32, counter width; must be an integer multiple (1..4) of DATA_WIDTH
NUM_EVENTS, 2, extra generic event inputs (0..8)
SATURATE, 1, 1 = counters hold at max on overflow, 0 = counters wrap to 0
Derived: NCNT = 4+NUM_EVENTS; SEL_W = clog2(NCNT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; clears counters/overflow, enters RUN
stop  in  1  pulse; RUN -> FROZEN
pc  in  PC_WIDTH  current CPU program counter
mem_read  in  1  bus read strobe
mem_write  in  1  bus write strobe
halted  in  1  CPU halted flag
event_in  in  max(NUM_EVENTS,1)  generic per-cycle event strobes
rd_en  in  1  readout request
rd_sel  in  SEL_W  counter index: 0 cycles, 1 instructions, 2 reads, 3 writes, 4+k event k
rd_word  in  2  word index within counter, 0 = least significant
rd_data  out  DATA_WIDTH  readout data
rd_valid  out  1  one-cycle pulse, qualifies rd_data
running  out  1  high in RUN
done  out  1  high in FROZEN
overflow  out  NCNT  sticky per-counter overflow flags

Behaviour:
- States: IDLE (reset state), RUN, FROZEN. Counters change only in RUN.
- Reset (async): state IDLE; all counters, shadow, last_pc (all ones), overflow, rd_data, rd_valid, running and done are set to 0, except last_pc.
- `start` in any state, sampled at an edge: counters and overflow go to 0, last_pc goes to all ones, and the next state is RUN.
  - `start` has priority over `halted` and `stop` at the same edge.
  - The start edge itself counts nothing.
- RUN, at an edge with `halted`=0 and `stop`=0:
  - cycles += 1.
  - instructions += 1 if `pc` != last_pc; last_pc <= `pc`.
  - reads += `mem_read`; writes += `mem_write`; event k += `event_in[k]`.
  - All counters update in parallel. Simultaneous `mem_read` and `mem_write` increment both.
- RUN, at an edge with `halted`=1 or `stop`=1: transition to FROZEN; no counter increments at that edge.
- FROZEN: counters hold and `done`=1. It is left only by `start` or `reset`. IDLE is left only by `start`.
- Overflow when incrementing a counter at max value:
  - SATURATE=1: the counter holds at all ones and its overflow bit is set.
  - SATURATE=0: the counter wraps to 0 and its overflow bit is set.
  - Overflow bits are sticky until `start` or `reset`.
- Readout (operates in any state, concurrent with counting, latency 1):
  - `rd_en` with `rd_word`=0: the shadow register latches the full value of counter[`rd_sel`] as it is before this edge's increment. The next cycle presents shadow[DATA_WIDTH-1:0] on rd_data with `rd_valid`=1.
  - `rd_en` with `rd_word`=w>0: no relatch; the next cycle presents shadow slice w.
  - `rd_word` at or above CNT_WIDTH/DATA_WIDTH, or `rd_sel` >= NCNT: rd_data=0 and `rd_valid`=1.
  - `rd_valid` is low on cycles without a request. `rd_data` holds its last value.
  - Back-to-back `rd_en` on consecutive cycles is supported.

Test Plan:
- Assert `reset` during RUN with counters nonzero, asynchronously mid-cycle -> immediately all outputs 0, state IDLE. A following `start` plus 5 cycles gives cycles=5.
- `start`, then `pc` 0,0,1,2,2,3 on six edges, then `halted`=1 -> cycles=6, instructions=4, `done`=1, `running`=0. Further `pc` changes leave counters unchanged.
- In RUN over 6 cycles, drive `mem_read` on 3 cycles and `mem_write` on 2 cycles, one cycle with both high -> reads=3, writes=2, overflow=0.
- Instance with CNT_WIDTH=16 and DATA_WIDTH=8; run 65537 counted cycles:
  - SATURATE=1 -> cycles=0xFFFF, overflow[0]=1.
  - SATURATE=0 -> cycles=0x0001, overflow[0]=1.
- Coherent snapshot with cycles=0x0000FFFF: `rd_en` with sel 0, word 0 -> rd_data=0xFFFF one cycle later. Keep counting 3 cycles, then read word 1 -> 0x0000, not 0x0001. `rd_sel`=7 with NUM_EVENTS=2 -> rd_data=0 and `rd_valid`=1.
- From FROZEN with nonzero counters and overflow, pulse `start` together with `halted`=1 -> counters=0, overflow=0, state RUN (`start` wins). The next edge with `halted`=1 -> FROZEN with cycles=0.
